// File: rtl/gauss_frame_seq.sv
// Frame sequencer for a cascaded Gaussian filter pair: streams rows from the
// source FIFO, inserts zero padding after each row and flushes the filter pipeline.
module gauss_frame_seq #(
  parameter int IMG_W = 400,
  parameter int IMG_H = 300,
  parameter int PAD   = 2,
  parameter int PRIME = 806
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       src_valid,
  input  logic [7:0] src_din,
  output logic       src_rd_en,
  output logic       filt_en,
  output logic [7:0] filt_din,
  input  logic [7:0] filt_dout,
  input  logic       dst_full,
  output logic       dst_wr_en,
  output logic [7:0] dst_din,
  output logic       busy,
  output logic       frame_done
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_RUN   | moving source pixels of the current row into the filter
  // S_PAD   | pushing zero pixels after a row
  // S_FLUSH | pushing zeros to drain the filter pipeline after the last row
  // S_DONE  | one-cycle frame_done, counters cleared
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAD, S_FLUSH, S_DONE} state_t;

  localparam int CW = $clog2(IMG_W) + 1;
  localparam int PW = $clog2(PAD) + 1;
  localparam int RW = $clog2(IMG_H) + 1;
  localparam int QW = $clog2(PRIME) + 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [PW-1:0] PAD_LAST   = PW'(PAD - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [QW-1:0] PRIME_MAX  = QW'(PRIME);
  localparam logic [QW-1:0] FLUSH_LAST = QW'(PRIME - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [PW-1:0] pad_cnt, pad_cnt_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [QW-1:0] prime_cnt, prime_cnt_nxt;
  logic [QW-1:0] flush_cnt, flush_cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      col       <= '0;
      pad_cnt   <= '0;
      row       <= '0;
      prime_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      pad_cnt   <= pad_cnt_nxt;
      row       <= row_nxt;
      prime_cnt <= prime_cnt_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    col_nxt       = col;
    pad_cnt_nxt   = pad_cnt;
    row_nxt       = row;
    prime_cnt_nxt = prime_cnt;
    flush_cnt_nxt = flush_cnt;
    src_rd_en     = 1'b0;
    filt_en       = 1'b0;
    filt_din      = '0;
    frame_done    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (src_valid && !dst_full) begin
          src_rd_en = 1'b1;
          filt_en   = 1'b1;
          filt_din  = src_din;
          if (col == COL_LAST) begin
            col_nxt   = '0;
            state_nxt = S_PAD;
          end else begin
            col_nxt = col + 1'b1;
          end
        end
      end
      S_PAD: begin
        if (!dst_full) begin
          filt_en = 1'b1;
          if (pad_cnt == PAD_LAST) begin
            pad_cnt_nxt = '0;
            row_nxt     = row + 1'b1;
            state_nxt   = (row == ROW_LAST) ? S_FLUSH : S_RUN;
          end else begin
            pad_cnt_nxt = pad_cnt + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (!dst_full) begin
          filt_en       = 1'b1;
          flush_cnt_nxt = flush_cnt + 1'b1;
          if (flush_cnt == FLUSH_LAST) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        frame_done    = 1'b1;
        col_nxt       = '0;
        pad_cnt_nxt   = '0;
        row_nxt       = '0;
        prime_cnt_nxt = '0;
        flush_cnt_nxt = '0;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // prime_cnt counts pushes until the filter output becomes meaningful
    if (filt_en && (prime_cnt != PRIME_MAX)) prime_cnt_nxt = prime_cnt + 1'b1;
  end

  assign dst_wr_en = filt_en && (prime_cnt == PRIME_MAX);
  assign dst_din   = filt_dout;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_gauss_frame_seq.sv
// Scoreboard bench for gauss_frame_seq with a 4x2 frame, PAD=2, PRIME=3.
module tb_gauss_frame_seq;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int PAD   = 2;
  localparam int PRIME = 3;
  localparam int N_PUSH = IMG_H * (IMG_W + PAD) + PRIME;

  logic       clk;
  logic       rst;
  logic       start;
  logic       src_valid;
  logic [7:0] src_din;
  logic       src_rd_en;
  logic       filt_en;
  logic [7:0] filt_din;
  logic [7:0] filt_dout;
  logic       dst_full;
  logic       dst_wr_en;
  logic [7:0] dst_din;
  logic       busy;
  logic       frame_done;

  gauss_frame_seq #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PAD(PAD), .PRIME(PRIME)) dut (
    .clk(clk), .rst(rst), .start(start), .src_valid(src_valid), .src_din(src_din),
    .src_rd_en(src_rd_en), .filt_en(filt_en), .filt_din(filt_din), .filt_dout(filt_dout),
    .dst_full(dst_full), .dst_wr_en(dst_wr_en), .dst_din(dst_din), .busy(busy),
    .frame_done(frame_done)
  );

  typedef struct {
    int din;
    int wr;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   seq[15] = '{1, 2, 3, 4, 0, 0, 5, 6, 7, 8, 0, 0, 0, 0, 0};

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   n_push = 0;
  int   n_wr = 0;
  int   pix = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void chk(string name, int act, int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push_exp(int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.din = seq[i];
      e.wr  = (i >= PRIME) ? 1 : 0;
      exp_q.push_back(e);
    end
  endfunction

  // monitor: samples on the falling edge, pops expectations on each filter push
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      n_push = 0;
      n_wr   = 0;
    end else begin
      if (filt_en) begin
        n_push++;
        if (exp_q.size() == 0) begin
          chk("unexpected_push", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("filt_din", int'(filt_din), e.din);
          chk("dst_wr_en", int'(dst_wr_en), e.wr);
        end
      end else begin
        chk("filt_din_idle_zero", int'(filt_din), 0);
      end
      if (dst_wr_en) begin
        n_wr++;
        chk("dst_din", int'(dst_din), int'(filt_dout));
      end
      if (dst_full) chk("stall_on_full", int'(filt_en | src_rd_en | dst_wr_en), 0);
      if (!src_valid) chk("rd_without_valid", int'(src_rd_en), 0);
      if (frame_done) begin
        if (done_q.size() == 0) chk("frame_done_unexpected", 1, 0);
        else chk("frame_done_cycle", cyc, done_q.pop_front());
        chk("push_total", n_push, N_PUSH);
        chk("wr_total", n_wr, N_PUSH - PRIME);
        n_push = 0;
        n_wr   = 0;
        done_cnt++;
      end
    end
  end

  task automatic step(input bit sv, input bit df, input bit st);
    bit rd;
    src_valid = sv;
    dst_full  = df;
    start     = st;
    src_din   = 8'(pix);
    filt_dout = 8'(cyc * 7 + 3);
    @(negedge clk);
    rd = src_rd_en;
    @(posedge clk);
    #1;
    if (rd) pix++;
    start = 1'b0;
  endtask

  // mode 0 nominal, 1 backpressure, 2 starvation, 3 start repeated during RUN
  task automatic run_frame(input int mode);
    int s, d0, rel;
    bit sv, df, st;
    push_exp(N_PUSH);
    pix = 1;
    d0  = done_cnt;
    s   = cyc;
    case (mode)
      1:       done_q.push_back(s + 21);
      2:       done_q.push_back(s + 24);
      default: done_q.push_back(s + 16);
    endcase
    step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 80 && done_cnt == d0; k++) begin
      rel = cyc - s;
      sv  = (mode == 2) ? (rel % 2 == 0) : 1'b1;
      df  = (mode == 1) && (rel >= 3) && (rel <= 7);
      st  = (mode == 3) && (rel == 3);
      step(sv, df, st);
    end
    chk($sformatf("frame_completed_mode%0d", mode), done_cnt - d0, 1);
    chk("exp_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    done_q.delete();
  endtask

  task automatic reset_mid_pad();
    int d0;
    push_exp(IMG_W);
    pix = 1;
    step(1'b1, 1'b0, 1'b1);
    repeat (IMG_W) step(1'b1, 1'b0, 1'b0);
    chk("in_pad_busy", int'(busy), 1);
    chk("in_pad_filt_en", int'(filt_en), 1);
    rst = 1'b0;
    #1;
    chk("async_reset_outputs",
        int'({src_rd_en, filt_en, dst_wr_en, busy, frame_done, filt_din}), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    d0 = done_cnt;
    repeat (10) step(1'b1, 1'b0, 1'b0);
    chk("no_done_after_abort", done_cnt - d0, 0);
    chk("idle_after_abort", int'(busy), 0);
    chk("abort_queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    src_valid = 1'b0;
    src_din   = '0;
    dst_full  = 1'b0;
    filt_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        int'({src_rd_en, filt_en, dst_wr_en, busy, frame_done, filt_din}), 0);
    rst = 1'b1;
    repeat (2) step(1'b1, 1'b0, 1'b0);
    chk("idle_without_start", int'(busy), 0);

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    repeat (20) step(1'b1, 1'b0, 1'b0);
    chk("idle_after_single_frame", int'(busy), 0);
    reset_mid_pad();
    run_frame(0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gauss_frame_seq.md
GAUSS_FRAME_SEQ -- requirements
Module: gauss_frame_seq

Interface
REQ-001 Parameter IMG_W, default 400, pixels per row.
REQ-002 Parameter IMG_H, default 300, rows per frame.
REQ-003 Parameter PAD, default 2, zero pixels inserted after each row; range 1..15.
REQ-004 Parameter PRIME, default 806, filter pushes before its first valid output; range 1..1023.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle frame start request.
REQ-008 src_valid  in  1  upstream FIFO holds a pixel.
REQ-009 src_din  in  8  upstream pixel.
REQ-010 src_rd_en  out  1  pop upstream FIFO.
REQ-011 filt_en  out  1  shift enable to the cascaded Gaussian filter pair.
REQ-012 filt_din  out  8  pixel into the filter.
REQ-013 filt_dout  in  8  filter output.
REQ-014 dst_full  in  1  downstream FIFO full.
REQ-015 dst_wr_en  out  1  push downstream FIFO.
REQ-016 dst_din  out  8  pixel to downstream FIFO.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 frame_done  out  1  one-cycle pulse at end of frame.

Function
REQ-019 States are IDLE, RUN, PAD, FLUSH and DONE; the state register is the only state besides counters col, pad_cnt, row, prime_cnt and flush_cnt.
REQ-020 IDLE -> RUN when start=1; start in any other state is ignored.
REQ-021 In RUN, a push occurs when src_valid=1 and dst_full=0: src_rd_en=1, filt_en=1, filt_din=src_din, col increments.
REQ-022 In RUN, src_valid=0 or dst_full=1 stalls: src_rd_en=0, filt_en=0, no counter changes.
REQ-023 A RUN push with col=IMG_W-1 clears col and moves to PAD.
REQ-024 In PAD, each cycle with dst_full=0 pushes a zero (filt_en=1, filt_din=0, src_rd_en=0) and increments pad_cnt; dst_full=1 stalls.
REQ-025 The PAD push with pad_cnt=PAD-1 clears pad_cnt and increments row; the next state is FLUSH if row was IMG_H-1, else RUN.
REQ-026 In FLUSH, each cycle with dst_full=0 pushes a zero and increments flush_cnt; the push with flush_cnt=PRIME-1 moves to DONE.
REQ-027 DONE lasts one cycle, asserts frame_done, clears col, pad_cnt, row, prime_cnt and flush_cnt, then moves to IDLE.
REQ-028 prime_cnt increments on every push while below PRIME and saturates at PRIME.
REQ-029 dst_wr_en = filt_en AND (prime_cnt = PRIME), evaluated combinationally in the same cycle; dst_din = filt_dout.
REQ-030 Per frame, pushes total IMG_H*(IMG_W+PAD)+PRIME and dst_wr_en pulses total exactly IMG_H*(IMG_W+PAD).
REQ-031 dst_wr_en is never asserted while dst_full=1.
REQ-032 src_rd_en is never asserted while src_valid=0 or outside RUN.
REQ-033 filt_en=0 in IDLE and DONE; filt_din=0 whenever filt_en=0.
REQ-034 Counter widths are clog2 of their terminal value plus 1, with no wrap inside a frame.

Reset
REQ-035 rst=0 asynchronously forces IDLE, clears all counters, and drives src_rd_en, filt_en, dst_wr_en, busy and frame_done to 0, and filt_din to 0.
REQ-036 Reset asserted mid-frame abandons the frame; no frame_done is produced; after release the block waits for start.
REQ-037 The filter pipeline is not flushed by this block on reset; it is reset by the same rst.

Verification (bench parameters IMG_W=4, IMG_H=2, PAD=2, PRIME=3)
REQ-038 Nominal frame: start, src_valid held 1, dst_full held 0 -> 15 filt_en pulses, 12 dst_wr_en pulses, first dst_wr_en on 4th push, frame_done 16 cycles after start (15 push cycles + DONE).
REQ-039 Padding order: pixels 1..8 -> filt_din sequence 1,2,3,4,0,0,5,6,7,8,0,0,0,0,0.
REQ-040 Backpressure: dst_full=1 for 5 cycles mid-RUN -> filt_en, src_rd_en and dst_wr_en all 0 for those 5 cycles; totals unchanged; frame_done delayed by 5 cycles.
REQ-041 Starvation: src_valid low every other cycle -> no src_rd_en while src_valid=0; PAD and FLUSH proceed without src_valid; totals 15/12.
REQ-042 Reset mid-PAD: rst=0 for 1 cycle during row 0 PAD -> all outputs 0 immediately, IDLE, no frame_done; start then yields a full 15/12 frame.
REQ-043 start asserted during RUN -> ignored; exactly one frame_done.
